// File: rtl/memory_control_if.sv
// Requester and RAM side bus of memory_control.
// slave: controller view, master: environment view.
interface memory_control_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        memerr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN,
    input  daddr, dstore,
    input  ramload, ramstate,
    output ihit, dhit, iload, dload,
    output ramREN, ramWEN,
    output ramaddr, ramstore,
    output memerr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN,
    output daddr, dstore,
    output ramload, ramstate,
    input  ihit, dhit, iload, dload,
    input  ramREN, ramWEN,
    input  ramaddr, ramstore,
    input  memerr
  );
endinterface

// File: rtl/memory_control.sv
// Arbitrates instruction/data requests onto one RAM port.
// Ports: CLK, RST (sync, active high), bus (slave).
module memory_control (
  input  logic               CLK,
  input  logic               RST,
  memory_control_if.slave    bus
);
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    DACC,
    IACC,
    HIT,
    ERR
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic        ihit_q;
  logic        dhit_q;
  logic [31:0] iload_q;
  logic [31:0] dload_q;
  logic        ren_q;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] store_q;
  logic        err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.dREN || bus.dWEN) begin
            // write wins when both strobes are set
            state   <= DACC;
            op_wr   <= bus.dWEN;
            addr_q  <= bus.daddr;
            store_q <= bus.dstore;
            wen_q   <= bus.dWEN;
            ren_q   <= ~bus.dWEN;
          end else if (bus.iREN) begin
            state   <= IACC;
            op_wr   <= 1'b0;
            addr_q  <= bus.iaddr;
            store_q <= '0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b1;
          end
        end
        DACC, IACC: begin
          // RAM outputs come only from the latched copies
          if (bus.ramstate == RS_ACCESS) begin
            state   <= HIT;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            if (state == IACC) begin
              iload_q <= bus.ramload;
              ihit_q  <= 1'b1;
            end else begin
              if (!op_wr) dload_q <= bus.ramload;
              dhit_q <= 1'b1;
            end
          end else if (bus.ramstate == RS_ERROR
                       || cnt == 4'hF) begin
            state   <= ERR;
            err_q   <= 1'b1;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HIT: begin
          state  <= IDLE;
          ihit_q <= 1'b0;
          dhit_q <= 1'b0;
        end
        ERR: begin
          err_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.memerr   = err_q;
endmodule

// File: tb/tb_memory_control.sv
// Directed bench for memory_control.
// Inputs driven 1ns after CLK rise, outputs checked there.
module tb_memory_control;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  memory_control_if bus ();

  memory_control dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iREN = 0; bus.iaddr = 0;
    bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0;
    bus.ramload = 0; bus.ramstate = FREE;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1;
    bus.iREN = 1;
    tick();
    tick();
    n_chk++;
    if ({bus.ihit, bus.dhit} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_hits: got %b want 00",
               {bus.ihit, bus.dhit});
    end
    n_chk++;
    if ({bus.ramREN, bus.ramWEN, bus.memerr} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 000",
               {bus.ramREN, bus.ramWEN, bus.memerr});
    end
    n_chk++;
    if ({bus.ramaddr, bus.iload, bus.dload} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0",
               {bus.ramaddr, bus.iload, bus.dload});
    end
    RST = 0;
    bus.iREN = 0;
    tick();
  endtask

  task automatic test_iread();
    bus.iREN = 1; bus.iaddr = 32'h40;
    tick();
    n_chk++;
    if ({bus.ramREN, bus.ramWEN} !== 2'b10
        || bus.ramaddr !== 32'h40) begin
      n_fail++;
      $display("FAIL iread_req: got ren/wen %b addr %h want 10 40",
               {bus.ramREN, bus.ramWEN}, bus.ramaddr);
    end
    bus.ramstate = ACCESS; bus.ramload = 32'h8C010004;
    tick();
    n_chk++;
    if (bus.ihit !== 1 || bus.dhit !== 0
        || bus.iload !== 32'h8C010004) begin
      n_fail++;
      $display("FAIL iread_hit: got ihit %b dhit %b iload %h want 1 0 8c010004",
               bus.ihit, bus.dhit, bus.iload);
    end
    bus.iREN = 0; bus.ramstate = FREE; bus.ramload = 0;
    tick();
    n_chk++;
    if (bus.ihit !== 0 || bus.iload !== 32'h8C010004) begin
      n_fail++;
      $display("FAIL iread_hold: got ihit %b iload %h want 0 8c010004",
               bus.ihit, bus.iload);
    end
  endtask

  task automatic test_priority();
    bus.iREN = 1; bus.iaddr = 32'h44;
    bus.dREN = 1; bus.daddr = 32'h100;
    tick();
    n_chk++;
    if (bus.ramaddr !== 32'h100 || bus.ramREN !== 1) begin
      n_fail++;
      $display("FAIL prio_data_first: got addr %h ren %b want 100 1",
               bus.ramaddr, bus.ramREN);
    end
    bus.ramstate = ACCESS; bus.ramload = 32'h11111111;
    tick();
    n_chk++;
    if ({bus.dhit, bus.ihit} !== 2'b10
        || bus.dload !== 32'h11111111) begin
      n_fail++;
      $display("FAIL prio_dhit: got d/i %b dload %h want 10 11111111",
               {bus.dhit, bus.ihit}, bus.dload);
    end
    bus.dREN = 0; bus.ramstate = FREE;
    tick();
    n_chk++;
    if ({bus.dhit, bus.ihit, bus.ramREN} !== 3'b000) begin
      n_fail++;
      $display("FAIL prio_gap: got %b want 000",
               {bus.dhit, bus.ihit, bus.ramREN});
    end
    tick();
    n_chk++;
    if (bus.ramaddr !== 32'h44 || bus.ramREN !== 1) begin
      n_fail++;
      $display("FAIL prio_iacc: got addr %h ren %b want 44 1",
               bus.ramaddr, bus.ramREN);
    end
    bus.ramstate = ACCESS; bus.ramload = 32'h22222222;
    tick();
    n_chk++;
    if ({bus.dhit, bus.ihit} !== 2'b01
        || bus.iload !== 32'h22222222
        || bus.dload !== 32'h11111111) begin
      n_fail++;
      $display("FAIL prio_ihit: got d/i %b iload %h dload %h",
               {bus.dhit, bus.ihit}, bus.iload, bus.dload);
    end
    bus.iREN = 0; bus.ramstate = FREE;
    tick();
  endtask

  task automatic test_write();
    bus.dWEN = 1; bus.daddr = 32'h200;
    bus.dstore = 32'hDEADBEEF;
    bus.ramstate = BUSY;
    tick();
    // scramble requester inputs; RAM side must not move
    bus.daddr = 32'h999; bus.dstore = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (bus.ramWEN !== 1 || bus.ramREN !== 0
          || bus.ramaddr !== 32'h200
          || bus.ramstore !== 32'hDEADBEEF
          || bus.dhit !== 0) begin
        n_fail++;
        $display("FAIL write_cyc%0d: got wen %b ren %b addr %h data %h dhit %b",
                 i, bus.ramWEN, bus.ramREN, bus.ramaddr,
                 bus.ramstore, bus.dhit);
      end
      bus.ramstate = (i == 3) ? ACCESS : BUSY;
      bus.ramload = 32'hBAD0BAD0;
      tick();
    end
    n_chk++;
    if (bus.dhit !== 1 || bus.ramWEN !== 0
        || bus.dload !== 32'h11111111) begin
      n_fail++;
      $display("FAIL write_hit: got dhit %b wen %b dload %h want 1 0 11111111",
               bus.dhit, bus.ramWEN, bus.dload);
    end
    bus.dWEN = 0; bus.ramstate = FREE;
    tick();
  endtask

  task automatic test_timeout(input bit late_access);
    bus.dREN = 1; bus.daddr = 32'h300;
    bus.ramstate = BUSY;
    tick();
    for (int k = 1; k <= 15; k++) begin
      if (k == 15) begin
        n_chk++;
        if (bus.ramREN !== 1 || bus.memerr !== 0) begin
          n_fail++;
          $display("FAIL tmo_c15: got ren %b err %b want 1 0",
                   bus.ramREN, bus.memerr);
        end
      end
      tick();
    end
    if (late_access) begin
      bus.ramstate = ACCESS; bus.ramload = 32'h33333333;
    end
    tick();
    if (late_access) begin
      n_chk++;
      if (bus.dhit !== 1 || bus.memerr !== 0
          || bus.dload !== 32'h33333333) begin
        n_fail++;
        $display("FAIL tmo_access16: got dhit %b err %b dload %h",
                 bus.dhit, bus.memerr, bus.dload);
      end
      bus.dREN = 0; bus.ramstate = FREE;
      tick();
    end else begin
      n_chk++;
      if (bus.memerr !== 1 || bus.ramREN !== 0
          || bus.dhit !== 0) begin
        n_fail++;
        $display("FAIL tmo_err: got err %b ren %b dhit %b want 1 0 0",
                 bus.memerr, bus.ramREN, bus.dhit);
      end
      bus.ramstate = ACCESS;
      tick();
      tick();
      n_chk++;
      if (bus.memerr !== 1 || bus.dhit !== 0
          || bus.ramREN !== 0) begin
        n_fail++;
        $display("FAIL tmo_sticky: got err %b dhit %b ren %b want 1 0 0",
                 bus.memerr, bus.dhit, bus.ramREN);
      end
      idle_inputs();
      RST = 1;
      tick();
      RST = 0;
    end
  endtask

  task automatic test_ram_error();
    bus.iREN = 1; bus.iaddr = 32'h80;
    tick();
    bus.ramstate = ERROR;
    tick();
    n_chk++;
    if (bus.memerr !== 1 || bus.ihit !== 0
        || bus.ramREN !== 0) begin
      n_fail++;
      $display("FAIL ramerr: got err %b ihit %b ren %b want 1 0 0",
               bus.memerr, bus.ihit, bus.ramREN);
    end
    bus.ramstate = ACCESS;
    tick();
    n_chk++;
    if (bus.ihit !== 0 || bus.memerr !== 1) begin
      n_fail++;
      $display("FAIL ramerr_hold: got ihit %b err %b want 0 1",
               bus.ihit, bus.memerr);
    end
    RST = 1;
    tick();
    n_chk++;
    if (bus.memerr !== 0 || bus.ramREN !== 0
        || bus.ihit !== 0) begin
      n_fail++;
      $display("FAIL ramerr_rst: got err %b ren %b ihit %b want 0 0 0",
               bus.memerr, bus.ramREN, bus.ihit);
    end
    RST = 0;
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    bus.dREN = 1; bus.daddr = 32'h400;
    bus.ramstate = BUSY;
    tick();
    tick();
    RST = 1;
    bus.ramstate = ACCESS; bus.ramload = 32'h55555555;
    tick();
    n_chk++;
    if (bus.dhit !== 0 || bus.ramREN !== 0
        || bus.ramaddr !== 0 || bus.dload !== 0
        || bus.iload !== 0) begin
      n_fail++;
      $display("FAIL rstmid: got dhit %b ren %b addr %h dload %h iload %h",
               bus.dhit, bus.ramREN, bus.ramaddr,
               bus.dload, bus.iload);
    end
    RST = 0;
    bus.ramstate = FREE;
    tick();
    n_chk++;
    if (bus.ramREN !== 1 || bus.ramaddr !== 32'h400) begin
      n_fail++;
      $display("FAIL rstmid_req: got ren %b addr %h want 1 400",
               bus.ramREN, bus.ramaddr);
    end
    bus.ramstate = ACCESS; bus.ramload = 32'h44444444;
    tick();
    n_chk++;
    if (bus.dhit !== 1 || bus.dload !== 32'h44444444) begin
      n_fail++;
      $display("FAIL rstmid_hit: got dhit %b dload %h want 1 44444444",
               bus.dhit, bus.dload);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_iread();
    test_priority();
    test_write();
    test_timeout(1'b1);
    test_timeout(1'b0);
    test_ram_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  always @(negedge CLK) begin
    if (bus.ihit === 1'b1 && bus.dhit === 1'b1) begin
      n_fail++;
      $display("FAIL hit_overlap: got ihit 1 dhit 1 want not both");
    end
  end
endmodule
